multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multicycle signed ALU: single-cycle arith/logic/shift ops, iterative shift-add multiply,
// and a restoring divider built only when MULTICYCLE_ALU_DIV_EN is defined.
module multicycle_alu #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic [3:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               overflow,
  output logic               div_by_zero,
  output logic               illegal_op
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
                         OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_LLS = 4'd7,
                         OP_LRS = 4'd8, OP_INC = 4'd9, OP_DEC = 4'd10;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef MULTICYCLE_ALU_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic               last, load;
  logic [WIDTH-1:0]   mag_a, mag_b, w;
  logic               sext;
  logic [2*WIDTH-1:0] acc, mcand, acc_nx;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [2*WIDTH-1:0] sc_res, fin_res, res_q;
  logic               sc_ovf, sc_dbz, sc_ill, fin_ovf, fin_dbz, fin_ill;
  logic               zero_q, ovf_q, dbz_q, ill_q;

  assign mag_a  = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign mag_b  = operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign last   = (cnt == CW'(WIDTH-1));
  assign acc_nx = mplier[0] ? acc + mcand : acc;

`ifdef MULTICYCLE_ALU_DIV_EN
  // rem stays below the divisor magnitude (<= 2^(WIDTH-1)), so WIDTH-1 bits suffice
  logic [WIDTH-1:0] quo, dvs, quo_nx, rem_nx, r_sh, q_s, r_s;
  logic [WIDTH-2:0] rem;
  logic             qneg, rneg, dovf, ge;

  always_comb begin
    r_sh   = {rem, quo[WIDTH-1]};
    ge     = (r_sh >= dvs);
    rem_nx = ge ? r_sh - dvs : r_sh;
    quo_nx = {quo[WIDTH-2:0], ge};
    q_s    = qneg ? -quo_nx : quo_nx;
    r_s    = rneg ? -rem_nx : rem_nx;
  end
`endif

  always_comb begin
    w      = '0;
    sext   = 1'b1;
    sc_ovf = 1'b0;
    sc_dbz = 1'b0;
    sc_ill = 1'b0;
    case (opcode)
      OP_ADD: begin
        w      = operand_a + operand_b;
        sc_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (w[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        w      = operand_a - operand_b;
        sc_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (w[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_MUL: ;
`ifdef MULTICYCLE_ALU_DIV_EN
      OP_DIV: sc_dbz = (operand_b == '0);
`endif
      OP_AND: w = operand_a & operand_b;
      OP_OR:  w = operand_a | operand_b;
      OP_XOR: w = operand_a ^ operand_b;
      OP_LLS: begin
        sext = 1'b0;
        w    = (operand_b >= WLIM) ? '0 : operand_a << operand_b;
      end
      OP_LRS: begin
        sext = 1'b0;
        w    = (operand_b >= WLIM) ? '0 : operand_a >> operand_b;
      end
      OP_INC: begin
        w      = operand_a + ONE;
        sc_ovf = (operand_a == MAXV);
      end
      OP_DEC: begin
        w      = operand_a - ONE;
        sc_ovf = (operand_a == MINV);
      end
      default: sc_ill = 1'b1;
    endcase
    sc_res = {{WIDTH{sext & w[WIDTH-1]}}, w};
    if (sc_dbz) sc_res = {operand_a, {WIDTH{1'b1}}};
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    fin_res  = sc_res;
    fin_ovf  = sc_ovf;
    fin_dbz  = sc_dbz;
    fin_ill  = sc_ill;
    case (state)
      IDLE: if (in_valid) begin
        if (opcode == OP_MUL) state_nx = MUL;
`ifdef MULTICYCLE_ALU_DIV_EN
        else if (opcode == OP_DIV && operand_b != '0) state_nx = DIV;
`endif
        else begin
          state_nx = DONE;
          load     = 1'b1;
        end
      end
      MUL: if (last) begin
        state_nx = DONE;
        load     = 1'b1;
        fin_res  = neg ? -acc_nx : acc_nx;
        fin_ovf  = 1'b0;
        fin_dbz  = 1'b0;
        fin_ill  = 1'b0;
      end
`ifdef MULTICYCLE_ALU_DIV_EN
      DIV: if (last) begin
        state_nx = DONE;
        load     = 1'b1;
        fin_res  = {r_s, q_s};
        fin_ovf  = dovf;
        fin_dbz  = 1'b0;
        fin_ill  = 1'b0;
      end
`endif
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      dovf <= 1'b0;
`endif
      res_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      dbz_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (in_valid) begin
          cnt    <= '0;
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, mag_a};
          mplier <= mag_b;
          neg    <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
`ifdef MULTICYCLE_ALU_DIV_EN
          quo  <= mag_a;
          rem  <= '0;
          dvs  <= mag_b;
          qneg <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
          rneg <= operand_a[WIDTH-1];
          dovf <= (operand_a == MINV) && (operand_b == '1);
`endif
        end
      end else begin
        cnt    <= cnt + CW'(1);
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
`ifdef MULTICYCLE_ALU_DIV_EN
        quo <= quo_nx;
        rem <= rem_nx[WIDTH-2:0];
`endif
      end
      if (load) begin
        res_q  <= fin_res;
        zero_q <= (fin_res == '0);
        ovf_q  <= fin_ovf;
        dbz_q  <= fin_dbz;
        ill_q  <= fin_ill;
      end
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign result      = res_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu (WIDTH=16): randomized requests checked every cycle against an
// arithmetic reference model, plus directed literal cases. Honors MULTICYCLE_ALU_DIV_EN.
module tb_multicycle_alu;
  localparam int W = 16;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
                         OP_XOR = 4'd6, OP_LLS = 4'd7, OP_LRS = 4'd8, OP_INC = 4'd9,
                         OP_DEC = 4'd10;

  logic           clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic           in_ready, out_valid, zero, overflow, div_by_zero, illegal_op;
  logic [W-1:0]   operand_a = '0, operand_b = '0;
  logic [3:0]     opcode = '0;
  logic [2*W-1:0] result;
  int             n_checks = 0, n_pass = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .overflow(overflow), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; logic z, ov, dz, il; int lat; } exp_t;
  typedef struct { logic [3:0] op; logic [15:0] a, b; int hold; logic [31:0] res; logic [3:0] flg; int lat; } dir_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Expected response straight from the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = '0; e.ov = 1'b0; e.dz = 1'b0; e.il = 1'b0; e.lat = 1;
    case (op)
      4'd0: begin s = sa + sb; e.res = sx(16'(s)); e.ov = (s > 64'sd32767) || (s < -64'sd32768); end
      4'd1: begin s = sa - sb; e.res = sx(16'(s)); e.ov = (s > 64'sd32767) || (s < -64'sd32768); end
      4'd2: begin e.res = 32'(sa * sb); e.lat = 17; end
`ifdef MULTICYCLE_ALU_DIV_EN
      4'd3: begin
        if (sb == 64'sd0) begin e.res = {a, 16'hFFFF}; e.dz = 1'b1; end
        else if (sa == -64'sd32768 && sb == -64'sd1) begin e.res = 32'h0000_8000; e.ov = 1'b1; e.lat = 17; end
        else begin e.res = {16'(sa % sb), 16'(sa / sb)}; e.lat = 17; end
      end
`endif
      4'd4: e.res = sx(a & b);
      4'd5: e.res = sx(a | b);
      4'd6: e.res = sx(a ^ b);
      4'd7: e.res = (b >= 16'd16) ? 32'h0 : {16'h0, 16'(a << b)};
      4'd8: e.res = (b >= 16'd16) ? 32'h0 : {16'h0, a >> b};
      4'd9: begin s = sa + 64'sd1; e.res = sx(16'(s)); e.ov = (s > 64'sd32767); end
      4'd10: begin s = sa - 64'sd1; e.res = sx(16'(s)); e.ov = (s < -64'sd32768); end
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  // Compare process: one outstanding request, checked on every falling edge.
  exp_t cur;
  bit   pend = 1'b0, seen = 1'b0;
  int   cyc = 0;
  always @(negedge clk) begin
    bit rel;
    rel = 1'b0;
    if (!reset) begin
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", result, 32'h0);
      chk("rst_flags", {zero, overflow, div_by_zero, illegal_op}, 4'h0);
      pend = 1'b0;
      seen = 1'b0;
    end else begin
      chk("in_ready", in_ready, !pend);
      if (pend) begin
        cyc++;
        if (out_valid) begin
          if (!seen) chk("latency", cyc, cur.lat);
          seen = 1'b1;
          chk("result", result, cur.res);
          chk("flags", {zero, overflow, div_by_zero, illegal_op}, {cur.z, cur.ov, cur.dz, cur.il});
          if (out_ready) rel = 1'b1;
        end else if (seen) begin
          chk("valid_held", out_valid, 1'b1);
          pend = 1'b0;
        end else if (cyc > cur.lat) begin
          chk("valid_timeout", out_valid, 1'b1);
          pend = 1'b0;
        end
      end else begin
        chk("idle_out_valid", out_valid, 1'b0);
      end
      if (in_valid && !pend) begin
        cur  = model(opcode, operand_a, operand_b);
        pend = 1'b1;
        seen = 1'b0;
        cyc  = 0;
      end else if (rel) begin
        pend = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    opcode = op; operand_a = a; operand_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits for the result, holds it for `hold` valid cycles, then releases it.
  // Junk requests are driven while busy; they must be ignored.
  task automatic wait_result(input int hold, output exp_t g);
    int n;
    bit got;
    n = 0; got = 1'b0;
    g.res = '0; g.z = 1'b0; g.ov = 1'b0; g.dz = 1'b0; g.il = 1'b0; g.lat = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      out_ready = 1'b0;
      if (out_valid) begin
        if (n == 0) g.lat = i + 1;
        if (n >= hold) begin
          got = 1'b1; out_ready = 1'b1;
          g.res = result; g.z = zero; g.ov = overflow; g.dz = div_by_zero; g.il = illegal_op;
        end
        n++;
      end
      if (got) in_valid = 1'b0;
      else begin
        in_valid = 1'($urandom); opcode = 4'($urandom);
        operand_a = 16'($urandom); operand_b = 16'($urandom);
      end
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (!got) chk("wait_timeout", out_valid, 1'b1);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'hFFFF;
      4: return 16'($urandom_range(0, 20));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    exp_t g;
    dir_t dq[$];
    dir_t d;
    logic [3:0] op;
    // flg = {zero, overflow, div_by_zero, illegal_op}
    dq.push_back('{OP_ADD, 16'hFFF6, 16'hFFF5, 0, 32'hFFFF_FFEB, 4'b0000, 1});
    dq.push_back('{OP_ADD, 16'h7FFF, 16'h0001, 0, 32'hFFFF_8000, 4'b0100, 1});
    dq.push_back('{OP_MUL, 16'hFFF9, 16'h0006, 0, 32'hFFFF_FFD6, 4'b0000, 17});
    dq.push_back('{OP_LRS, 16'h008A, 16'h0004, 5, 32'h0000_0008, 4'b0000, 1});  // 138>>4 = 8
    dq.push_back('{4'd13,  16'h1234, 16'h5678, 0, 32'h0000_0000, 4'b1001, 1});
    dq.push_back('{OP_LLS, 16'h0001, 16'h000F, 0, 32'h0000_8000, 4'b0000, 1});
    dq.push_back('{OP_LLS, 16'hFFFF, 16'h0010, 0, 32'h0000_0000, 4'b1000, 1});
    dq.push_back('{OP_INC, 16'h7FFF, 16'h0000, 0, 32'hFFFF_8000, 4'b0100, 1});
    dq.push_back('{OP_DEC, 16'h8000, 16'h0000, 0, 32'h0000_7FFF, 4'b0100, 1});
    dq.push_back('{OP_SUB, 16'h8000, 16'h0001, 1, 32'h0000_7FFF, 4'b0100, 1});
    dq.push_back('{OP_XOR, 16'h00FF, 16'h00FF, 0, 32'h0000_0000, 4'b1000, 1});
    dq.push_back('{OP_MUL, 16'h8000, 16'h8000, 2, 32'h4000_0000, 4'b0000, 17});
    dq.push_back('{OP_MUL, 16'h0000, 16'h1234, 0, 32'h0000_0000, 4'b1000, 17});
`ifdef MULTICYCLE_ALU_DIV_EN
    dq.push_back('{OP_DIV, 16'hFFE7, 16'h0004, 0, 32'hFFFF_FFFA, 4'b0000, 17});
    dq.push_back('{OP_DIV, 16'h0005, 16'h0000, 0, 32'h0005_FFFF, 4'b0010, 1});
    dq.push_back('{OP_DIV, 16'h8000, 16'hFFFF, 0, 32'h0000_8000, 4'b0100, 17});
`else
    dq.push_back('{OP_DIV, 16'h0005, 16'h0000, 0, 32'h0000_0000, 4'b1001, 1});
`endif

    #1 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;

    // first request goes out right after reset release
    foreach (dq[i]) begin
      d = dq[i];
      issue(d.op, d.a, d.b);
      wait_result(d.hold, g);
      chk($sformatf("dir%0d_res", i), g.res, d.res);
      chk($sformatf("dir%0d_flags", i), {g.z, g.ov, g.dz, g.il}, d.flg);
      chk($sformatf("dir%0d_lat", i), g.lat, d.lat);
    end

    // reset in the middle of a multiply aborts it
    issue(OP_ADD, 16'h0001, 16'h0001);
    wait_result(0, g);
    issue(OP_MUL, 16'h0003, 16'h0005);
    repeat (7) tick();
    reset = 1'b0;
    #1;
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_result", result, 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (25) tick();

    for (int t = 0; t < 250; t++) begin
      op = 4'($urandom_range(0, 15));
      issue(op, pick(), pick());
      wait_result(int'($urandom_range(0, 3)), g);
    end
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
